// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer for the fetch/decode boundary, falling-edge clocked.
// Optional stall/flush statistics enabled by defining PIPE_SKID_BUF_STATS_EN.
module pipe_skid_buf #(
   parameter int unsigned WIDTH = 64,
   parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready,
   input  logic             i_flush,
`ifdef PIPE_SKID_BUF_STATS_EN
   output logic [15:0]      o_stall_cnt,
   output logic [7:0]       o_flush_cnt,
`endif
   output logic [1:0]       o_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   assign o_ready = (state_q != FULL);
   assign o_valid = (state_q != EMPTY);
   assign o_data  = main_q;
   assign o_count = state_q;

   assign in_fire  = i_valid & o_ready;
   assign out_fire = o_valid & i_ready;

   // State and payload registers, updated on the falling edge
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Next state and payload moves; flush overrides every transfer
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (i_flush) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = i_data;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = i_data;
               end else if (in_fire) begin
                  skid_d  = i_data;
                  state_d = FULL;
               end else if (out_fire) begin
                  main_d  = NOP_VALUE;
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
                  state_d = BUSY;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_BUF_STATS_EN
   logic [15:0] stall_q;
   logic [7:0]  flush_q;

   assign o_stall_cnt = stall_q;
   assign o_flush_cnt = flush_q;

   // Saturating event counters, cleared only by reset
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (i_valid && !o_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (i_flush && flush_q != 8'hFF)
            flush_q <= flush_q + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_pipe_skid_buf;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic [63:0] i_data;
   logic        o_ready;
   logic        o_valid;
   logic [63:0] o_data;
   logic        i_ready;
   logic        i_flush;
   logic [1:0]  o_count;
`ifdef PIPE_SKID_BUF_STATS_EN
   logic [15:0] o_stall_cnt;
   logic [7:0]  o_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [63:0] mq[$];
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   pipe_skid_buf #(.WIDTH(64)) dut (
      .clk(clk),
      .rst(rst),
      .i_valid(i_valid),
      .i_data(i_data),
      .o_ready(o_ready),
      .o_valid(o_valid),
      .o_data(o_data),
      .i_ready(i_ready),
      .i_flush(i_flush),
`ifdef PIPE_SKID_BUF_STATS_EN
      .o_stall_cnt(o_stall_cnt),
      .o_flush_cnt(o_flush_cnt),
`endif
      .o_count(o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic        r;
      logic        f;
      logic        ev;
      logic [63:0] ed;
      logic [1:0]  ec;
      logic        er;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic v, input logic [63:0] d,
                             input logic r, input logic f);
      bit rdy;
      bit ovl;
      rdy = mq.size() < 2;
      ovl = mq.size() > 0;
      if (v && !rdy && m_stall != 32'hFFFF) m_stall++;
      if (f && m_flush != 32'hFF) m_flush++;
      if (f) begin
         mq.delete();
      end else begin
         if (ovl && r) void'(mq.pop_front());
         if (v && rdy) mq.push_back(d);
      end
   endtask

   task automatic step(input logic v, input logic [63:0] d,
                       input logic r, input logic f);
      @(posedge clk);
      #1;
      i_valid = v;
      i_data  = d;
      i_ready = r;
      i_flush = f;
      model_edge(v, d, r, f);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, 64'(o_valid), 64'(mq.size() > 0));
      chk({tag, ".data"}, o_data, (mq.size() > 0) ? mq[0] : 64'h0);
      chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
      chk({tag, ".ready"}, 64'(o_ready), 64'(mq.size() < 2));
`ifdef PIPE_SKID_BUF_STATS_EN
      chk({tag, ".stall"}, 64'(o_stall_cnt), 64'(m_stall));
      chk({tag, ".flush"}, 64'(o_flush_cnt), 64'(m_flush));
`endif
   endtask

   task automatic add(input logic v, input logic [63:0] d, input logic r,
                      input logic f, input logic ev, input logic [63:0] ed,
                      input logic [1:0] ec, input logic er);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.f = f;
      t.ev = ev; t.ed = ed; t.ec = ec; t.er = er;
      tbl.push_back(t);
   endtask

   initial begin
      rst = 1'b0;
      i_valid = 1'b0;
      i_data = '0;
      i_ready = 1'b0;
      i_flush = 1'b0;

      // streaming
      add(1, 64'h1, 1, 0, 1, 64'h1, 2'd1, 1);
      add(1, 64'h2, 1, 0, 1, 64'h2, 2'd1, 1);
      add(1, 64'h3, 1, 0, 1, 64'h3, 2'd1, 1);
      add(0, 64'h0, 1, 0, 0, 64'h0, 2'd0, 1);
      // backpressure
      add(1, 64'hA, 0, 0, 1, 64'hA, 2'd1, 1);
      add(1, 64'hB, 0, 0, 1, 64'hA, 2'd2, 0);
      add(1, 64'hC, 0, 0, 1, 64'hA, 2'd2, 0);
      add(1, 64'hC, 1, 0, 1, 64'hB, 2'd1, 1);
      add(1, 64'hC, 1, 0, 1, 64'hC, 2'd1, 1);
      add(0, 64'h0, 1, 0, 0, 64'h0, 2'd0, 1);
      // flush while full
      add(1, 64'h11, 0, 0, 1, 64'h11, 2'd1, 1);
      add(1, 64'h12, 0, 0, 1, 64'h11, 2'd2, 0);
      add(1, 64'hD, 0, 1, 0, 64'h0, 2'd0, 1);
      add(0, 64'h0, 0, 0, 0, 64'h0, 2'd0, 1);
      // simultaneous in/out in BUSY
      add(1, 64'h5, 0, 0, 1, 64'h5, 2'd1, 1);
      add(1, 64'h6, 1, 0, 1, 64'h6, 2'd1, 1);
      add(0, 64'h0, 1, 0, 0, 64'h0, 2'd0, 1);

      #2;
      chk("rst.valid", 64'(o_valid), 64'h0);
      chk("rst.ready", 64'(o_ready), 64'h1);
      chk("rst.count", 64'(o_count), 64'h0);
      chk("rst.data", o_data, 64'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
         chk($sformatf("vec%0d.valid", i), 64'(o_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d.data", i), o_data, tbl[i].ed);
         chk($sformatf("vec%0d.count", i), 64'(o_count), 64'(tbl[i].ec));
         chk($sformatf("vec%0d.ready", i), 64'(o_ready), 64'(tbl[i].er));
      end
`ifdef PIPE_SKID_BUF_STATS_EN
      chk("vec.stall", 64'(o_stall_cnt), 64'd3);
      chk("vec.flush", 64'(o_flush_cnt), 64'd1);
`endif

      // async reset between edges while FULL
      step(1, 64'h21, 0, 0);
      step(1, 64'h22, 0, 0);
      chk_model("prefull");
      #2 rst = 1'b0;
      #1;
      mq.delete();
      m_stall = 0;
      m_flush = 0;
      chk("arst.valid", 64'(o_valid), 64'h0);
      chk("arst.ready", 64'(o_ready), 64'h1);
      chk("arst.count", 64'(o_count), 64'h0);
      chk("arst.data", o_data, 64'h0);
`ifdef PIPE_SKID_BUF_STATS_EN
      chk("arst.stall", 64'(o_stall_cnt), 64'h0);
      chk("arst.flush", 64'(o_flush_cnt), 64'h0);
`endif
      @(posedge clk);
      #1 rst = 1'b1;
      step(1, 64'h31, 1, 0);
      chk("post_rst.data", o_data, 64'h31);
      chk_model("post_rst");

      // random traffic against the queue model
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom},
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0));
         chk_model($sformatf("rnd%0d", n));
      end

`ifdef PIPE_SKID_BUF_STATS_EN
      // stall counter saturation
      for (int n = 0; n < 70000; n++) step(1, 64'h77, 0, 0);
      chk("sat.stall", 64'(o_stall_cnt), 64'hFFFF);
      step(1, 64'h78, 0, 0);
      chk("sat.hold", 64'(o_stall_cnt), 64'hFFFF);
      chk_model("sat");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
